// File: rtl/uart_alici_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_alici_fifo
// Description : Receive-side byte buffer for a UART receiver. Captures each
//               byte flagged by the receiver's valid pulse into a first-word-
//               fall-through FIFO. Presents bytes over a ready/valid handshake
//               with occupancy, sticky overflow and threshold interrupt.
// Ports       : clk_i, rstn_i          - clock, async active-low reset
//               veri_i, veri_gecerli_i - incoming byte and its valid pulse
//               veri_o, veri_gecerli_o - head byte (0 when empty) and valid
//               veri_hazir_i           - consumer accepts head byte
//               bos_o, dolu_o          - empty / full
//               doluluk_o              - stored byte count 0..DERINLIK
//               esik_i, kesme_o        - interrupt threshold (0 = off), irq
//               tasma_o                - sticky overflow flag
//               tasma_temizle_i        - clears the overflow flag
// Revision    : 1.0 - initial release
// ============================================================================
module uart_alici_fifo #(
    parameter int DERINLIK = 8,
    parameter int VERI_BIT = 8
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic [VERI_BIT-1:0]         veri_i,
    input  logic                        veri_gecerli_i,
    output logic [VERI_BIT-1:0]         veri_o,
    output logic                        veri_gecerli_o,
    input  logic                        veri_hazir_i,
    output logic                        bos_o,
    output logic                        dolu_o,
    output logic [$clog2(DERINLIK):0]   doluluk_o,
    input  logic [$clog2(DERINLIK):0]   esik_i,
    output logic                        kesme_o,
    output logic                        tasma_o,
    input  logic                        tasma_temizle_i
);

    localparam int c_ADR_W = $clog2(DERINLIK);
    localparam int c_CNT_W = c_ADR_W + 1;

    logic [VERI_BIT-1:0] r_mem [DERINLIK];
    logic [c_CNT_W-1:0]  r_wr_ptr;
    logic [c_CNT_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_doluluk;
    logic                r_tasma;

    logic w_bos;
    logic w_dolu;
    logic w_push;
    logic w_pop;
    logic w_tasma;

    // Full/empty come from the count so pointer equality is never ambiguous.
    assign w_bos   = (r_doluluk == '0);
    assign w_dolu  = (r_doluluk == c_CNT_W'(DERINLIK));
    assign w_pop   = !w_bos && veri_hazir_i;
    // A simultaneous pop frees a slot, so a full FIFO still accepts the byte.
    assign w_push  = veri_gecerli_i && (!w_dolu || w_pop);
    assign w_tasma = veri_gecerli_i && w_dolu && !w_pop;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < DERINLIK; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr[c_ADR_W-1:0]] <= veri_i;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_doluluk <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_CNT_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_CNT_W'(1);
            end
            if (w_push && !w_pop) begin
                r_doluluk <= r_doluluk + c_CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_doluluk <= r_doluluk - c_CNT_W'(1);
            end
        end
    end

    // Set has priority over clear so a fresh overflow is never lost.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_tasma <= 1'b0;
        end else if (w_tasma) begin
            r_tasma <= 1'b1;
        end else if (tasma_temizle_i) begin
            r_tasma <= 1'b0;
        end
    end

    assign veri_o         = w_bos ? '0 : r_mem[r_rd_ptr[c_ADR_W-1:0]];
    assign veri_gecerli_o = !w_bos;
    assign bos_o          = w_bos;
    assign dolu_o         = w_dolu;
    assign doluluk_o      = r_doluluk;
    assign kesme_o        = (esik_i != '0) && (r_doluluk >= esik_i);
    assign tasma_o        = r_tasma;

endmodule
`default_nettype wire
